cmn_lfsr4_chk: RTL
==================

# cmn_lfsr4_chk

Checks a stream of 4-bit words against the x^4+x+1 LFSR sequence that the common 4-bit LFSR generator produces (next = {cur[2:0], cur[3]^cur[0]}, period 15, seed 0x1). It sits at the receiving end of a PRBS link or datapath under test. It self-synchronises by seeding from received data, declares lock after a run of correct predictions, then free-runs its own prediction. It reports mismatches as a pulse and as a saturating count.

## Interface
- LOCK_CNT, default 4: number of consecutive correctly predicted beats in HUNT needed to lock. Legal range 1..15.
- UNLOCK_CNT, default 3: number of consecutive mismatching beats in LOCKED needed to drop lock. Legal range 1..15.
- ERR_W, default 16: width of the error counter.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_vld  in  1  in_data carries a beat this cycle.
- in_data  in  4  received LFSR word.
- err_clr  in  1  synchronous clear of err_cnt.
- locked  out  1  checker is in the LOCKED state.
- err_pls  out  1  one-cycle pulse per mismatching beat while locked.
- err_cnt  out  ERR_W  saturating count of mismatching beats while locked.

## Operation
- State is HUNT or LOCKED.
- exp[3:0] holds the predicted value of the next beat. exp = 0 means "unseeded"; 0 is never a legal LFSR state.
- run[3:0] counts consecutive matches in HUNT, or consecutive misses in LOCKED.
- nxt(x) = {x[2:0], x[3]^x[0]}.
- Beats with in_vld = 0 are ignored: no register changes except err_clr, and err_pls = 0.
- HUNT, on a valid beat:
  - in_data == 0: exp <= 0, run <= 0.
  - exp != 0 and in_data == exp: exp <= nxt(in_data). If run+1 == LOCK_CNT, go to LOCKED with run <= 0; otherwise run <= run+1.
  - Otherwise: exp <= nxt(in_data), run <= 0. The beat becomes the new seed.
  - No errors are counted in HUNT.
- LOCKED, on a valid beat:
  - exp <= nxt(exp). The prediction free-runs and is never reseeded from data.
  - in_data == exp: run <= 0.
  - Otherwise: err_pls <= 1, err_cnt <= err_cnt+1 (saturating at all-ones), run <= run+1.
  - If a miss makes run+1 == UNLOCK_CNT: go to HUNT with run <= 0 and exp <= nxt(in_data), or exp <= 0 if in_data == 0.
- err_clr takes priority: err_cnt <= 0 + (error on the same beat ? 1 : 0).
- Reset values: state HUNT, exp 0, run 0, locked 0, err_pls 0, err_cnt 0.

## Timing
- All outputs are registered.
- locked rises on the cycle after the valid beat that completes LOCK_CNT matches. For a clean stream from reset, that is the (LOCK_CNT+1)-th valid beat, because the first beat only seeds.
- err_pls is high the cycle after the mismatching beat, for exactly one cycle per beat. Back-to-back bad beats give back-to-back pulses.
- err_cnt updates on the same edge as err_pls.
- locked falls the cycle after the UNLOCK_CNT-th consecutive miss. That beat is still counted as an error.
- rst_n low on any edge returns every register to its reset value, regardless of in_vld, err_clr or state.

## Configuration
- CMN_LFSR4_CHK_DIFF_EN
- Defined: adds output err_diff (out, 4 bits), reset 0.
  - On each beat that raises err_pls, err_diff is loaded with in_data ^ exp, on the same edge as err_pls.
  - It holds its value until the next error or reset; err_clr does not affect it.
- Undefined: the port and register are absent. All other behaviour is identical.

## Test plan
Reference sequence from seed 0x1: 1,3,7,F,E,D,A,5,B,6,C,9,2,4,8.
- Lock from reset: defaults, reset, then continuous beats 1,3,7,F,E -> locked = 1 on the cycle after beat E (no earlier); err_cnt = 0; err_pls never asserts.
- Single error: locked, continue with D,2 (A expected),5,B -> one err_pls, the cycle after the 2; err_cnt = 1; err_diff = 0x8 with DIFF_EN; locked stays 1; 5 and B match.
- Loss and relock: locked, then three bad beats 0,0,0 -> err_cnt = 3, locked falls after the third. Then 9,2,4,8,1 -> locked re-rises after the 1; err_cnt stays 3.
- Gaps: lock test with in_vld low for 5 cycles between every beat -> lock after the same 5 valid beats; no err_pls; state held across gaps.
- Zero stream: reset, then 40 valid beats of 0 -> locked stays 0; err_cnt = 0.
- Saturation and clear: ERR_W = 2, UNLOCK_CNT = 3. Locked, then alternate bad/good beats for 5 errors -> err_cnt = 3 (saturated); locked stays 1. Then err_clr with a bad beat on the same cycle -> err_cnt = 1. Then rst_n low for one edge mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/cmn_lfsr4_chk.sv
`default_nettype none
// ============================================================================
// Module   : cmn_lfsr4_chk
// Purpose  : x^4+x+1 LFSR stream checker; self-seeds from received data, locks,
//            then free-runs its prediction and counts mismatches.
//            Optional err_diff output under `CMN_LFSR4_CHK_DIFF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cmn_lfsr4_chk #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [3:0]       in_data,
    input  logic             err_clr,
`ifdef CMN_LFSR4_CHK_DIFF_EN
    output logic [3:0]       err_diff,
`endif
    output logic             locked,
    output logic             err_pls,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [0:0]       c_HUNT    = 1'b0;
    localparam logic [0:0]       c_LOCKED  = 1'b1;
    localparam logic [4:0]       c_LOCK_N  = 5'(LOCK_CNT);
    localparam logic [4:0]       c_UNLCK_N = 5'(UNLOCK_CNT);
    localparam logic [ERR_W-1:0] c_CNT_MAX = '1;

    logic [0:0]       r_state, w_state;
    logic [3:0]       r_exp, w_exp;
    logic [3:0]       r_run, w_run;
    logic             r_err_pls, w_err_pls;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt;
`ifdef CMN_LFSR4_CHK_DIFF_EN
    logic [3:0]       r_err_diff, w_err_diff;
`endif

    logic [3:0] w_nxt_in;
    logic [3:0] w_nxt_exp;
    logic [4:0] w_run_inc;
    logic       w_match;
    logic       w_err;

    assign w_nxt_in  = {in_data[2:0], in_data[3] ^ in_data[0]};
    assign w_nxt_exp = {r_exp[2:0], r_exp[3] ^ r_exp[0]};
    assign w_run_inc = {1'b0, r_run} + 5'd1;
    assign w_match   = (in_data == r_exp);
    // An error is only ever a valid, mispredicted beat while locked.
    assign w_err     = in_vld && (r_state == c_LOCKED) && !w_match;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_HUNT;
            r_exp     <= 4'h0;
            r_run     <= 4'h0;
            r_err_pls <= 1'b0;
            r_err_cnt <= '0;
`ifdef CMN_LFSR4_CHK_DIFF_EN
            r_err_diff <= 4'h0;
`endif
        end else begin
            r_state   <= w_state;
            r_exp     <= w_exp;
            r_run     <= w_run;
            r_err_pls <= w_err_pls;
            r_err_cnt <= w_err_cnt;
`ifdef CMN_LFSR4_CHK_DIFF_EN
            r_err_diff <= w_err_diff;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state   = r_state;
        w_exp     = r_exp;
        w_run     = r_run;
        w_err_pls = w_err;
        w_err_cnt = r_err_cnt;
`ifdef CMN_LFSR4_CHK_DIFF_EN
        w_err_diff = r_err_diff;
        if (w_err) begin
            w_err_diff = in_data ^ r_exp;
        end
`endif

        if (in_vld) begin
            case (r_state)
                c_HUNT: begin
                    if (in_data == 4'h0) begin
                        w_exp = 4'h0;
                        w_run = 4'h0;
                    end else if ((r_exp != 4'h0) && w_match) begin
                        w_exp = w_nxt_in;
                        if (w_run_inc == c_LOCK_N) begin
                            w_state = c_LOCKED;
                            w_run   = 4'h0;
                        end else begin
                            w_run = w_run_inc[3:0];
                        end
                    end else begin
                        w_exp = w_nxt_in;
                        w_run = 4'h0;
                    end
                end
                default: begin
                    w_exp = w_nxt_exp;
                    if (w_match) begin
                        w_run = 4'h0;
                    end else if (w_run_inc == c_UNLCK_N) begin
                        // Drop lock and reseed from the offending beat.
                        w_state = c_HUNT;
                        w_run   = 4'h0;
                        w_exp   = (in_data == 4'h0) ? 4'h0 : w_nxt_in;
                    end else begin
                        w_run = w_run_inc[3:0];
                    end
                end
            endcase
        end

        if (err_clr) begin
            w_err_cnt = w_err ? {{(ERR_W-1){1'b0}}, 1'b1} : '0;
        end else if (w_err && (r_err_cnt != c_CNT_MAX)) begin
            w_err_cnt = r_err_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all taken directly from registers)
    // ------------------------------------------------------------------
    always_comb begin
        locked  = (r_state == c_LOCKED);
        err_pls = r_err_pls;
        err_cnt = r_err_cnt;
`ifdef CMN_LFSR4_CHK_DIFF_EN
        err_diff = r_err_diff;
`endif
    end

endmodule
`default_nettype wire
